channel_dispatch: RTL and testbench

Upstream steering stage for the per-engine thread channels. Accepts one thread (PC + CC id) per cycle from an engine's output port and forwards it to whichever of `N_CHANNELS` downstream channel FIFOs reports the lowest estimated wait latency. Ties are broken round-robin. A one-entry holding register decouples the upstream handshake from the downstream ones. The block also exports its own latency estimate so it can be chained like a channel.

---
 rtl/channel_dispatch.sv | 129 ++++++++++++
 tb/tb_channel_dispatch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/channel_dispatch.sv
// channel_dispatch
// Steers one thread word per cycle into whichever downstream channel reports
// the lowest estimated wait latency, breaking ties round-robin. A one-entry
// holding register sits between the upstream and downstream handshakes.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake, in_data = {pc, cc_id}
//   in_latency      estimated wait for a thread accepted this cycle
//   out_valid       one-hot valid toward the chosen channel
//   out_ready       per-channel ready
//   out_data        held thread word, broadcast to all channels
//   out_latency     per-channel latency estimates, channel i at slice i
//   dispatch_count  per-channel delivered-thread counters, channel i at slice i
module channel_dispatch #(
  parameter int PC_WIDTH             = 8,
  parameter int CC_ID_BITS           = 2,
  parameter int N_CHANNELS           = 2,
  parameter int LATENCY_COUNT_WIDTH  = 10,
  parameter int DISPATCH_COUNT_WIDTH = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [PC_WIDTH+CC_ID_BITS-1:0]             in_data,
  output logic [LATENCY_COUNT_WIDTH-1:0]             in_latency,
  output logic [N_CHANNELS-1:0]                      out_valid,
  input  logic [N_CHANNELS-1:0]                      out_ready,
  output logic [PC_WIDTH+CC_ID_BITS-1:0]             out_data,
  input  logic [N_CHANNELS*LATENCY_COUNT_WIDTH-1:0]  out_latency,
  output logic [N_CHANNELS*DISPATCH_COUNT_WIDTH-1:0] dispatch_count
);

  localparam int DW = PC_WIDTH + CC_ID_BITS;
  localparam int LW = LATENCY_COUNT_WIDTH;
  localparam int CW = DISPATCH_COUNT_WIDTH;
  localparam int IW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [DW-1:0]   hold_data;
  logic [IW-1:0]   hold_dest;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   sel_next;
  logic [IW-1:0]   rr_next;
  logic [LW-1:0]   lat [N_CHANNELS];
  logic [LW-1:0]   min_lat;
  logic            out_transfer;
  logic            stalled;
  logic            accept;

  genvar gi;
  generate
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
      logic [CW-1:0] count_reg;

      assign lat[gi]       = out_latency[gi*LW +: LW];
      assign out_valid[gi] = (state == FULL) && (hold_dest == IW'(gi));
      assign dispatch_count[gi*CW +: CW] = count_reg;

      // Counter wraps naturally at all-ones.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg <= '0;
        end else if (out_transfer && (hold_dest == IW'(gi))) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign out_data     = hold_data;
  assign out_transfer = (state == FULL) && out_ready[hold_dest];
  assign stalled      = (state == FULL) && !out_transfer;
  assign in_ready     = (state == EMPTY) || out_transfer;
  assign accept       = in_valid && in_ready;

  always_comb begin
    min_lat = lat[0];
    for (int i = 1; i < N_CHANNELS; i++) begin
      if (lat[i] < min_lat) min_lat = lat[i];
    end
  end

  // Scan cyclically from rr_ptr; the first channel at the minimum wins the tie.
  always_comb begin
    logic found;
    int   idx;
    sel_next = '0;
    found    = 1'b0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
      if (!found && (lat[idx] == min_lat)) begin
        sel_next = IW'(idx);
        found    = 1'b1;
      end
    end
  end

  assign rr_next = (sel_next == IW'(N_CHANNELS - 1)) ? '0 : sel_next + 1'b1;

  // A stalled holding register adds one slot of wait ahead of a new thread.
  always_comb begin
    in_latency = min_lat;
    if (stalled && (min_lat != {LW{1'b1}})) in_latency = min_lat + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      hold_data <= '0;
      hold_dest <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        state     <= FULL;
        hold_data <= in_data;
        hold_dest <= sel_next;
        rr_ptr    <= rr_next;
      end else if (out_transfer) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_channel_dispatch.sv
module tb_channel_dispatch;

  localparam int DW  = 10;
  localparam int LW  = 10;
  localparam int CW  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [LW-1:0]   in_latency;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready = 2'b11;
  logic [DW-1:0]   out_data;
  logic [2*LW-1:0] out_latency = '0;
  logic [2*CW-1:0] dispatch_count;

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  channel_dispatch #(
    .PC_WIDTH(8), .CC_ID_BITS(2), .N_CHANNELS(2),
    .LATENCY_COUNT_WIDTH(LW), .DISPATCH_COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_latency(in_latency),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_latency(out_latency), .dispatch_count(dispatch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [1:0]    rdy;
    logic [LW-1:0] l1;
    logic [LW-1:0] l0;
    logic          e_ir;
    logic [1:0]    e_ov;
    logic [DW-1:0] e_od;
    logic [LW-1:0] e_lat;
    logic [CW-1:0] e_c0;
    logic [CW-1:0] e_c1;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_ir, input logic [1:0] e_ov,
                           input logic [DW-1:0] e_od, input logic [LW-1:0] e_lat,
                           input logic [CW-1:0] e_c0, input logic [CW-1:0] e_c1);
    n_vec++;
    chk({tag, ".in_ready"},   32'(in_ready),   32'(e_ir));
    chk({tag, ".out_valid"},  32'(out_valid),  32'(e_ov));
    chk({tag, ".out_data"},   32'(out_data),   32'(e_od));
    chk({tag, ".in_latency"}, 32'(in_latency), 32'(e_lat));
    chk({tag, ".count0"},     32'(dispatch_count[0 +: CW]),  32'(e_c0));
    chk({tag, ".count1"},     32'(dispatch_count[CW +: CW]), 32'(e_c1));
    $display("vec %s: iv=%0b d=%03h rdy=%02b lat=%0d/%0d -> ir=%0b ov=%02b od=%03h il=%0d c=%0d/%0d",
             tag, in_valid, in_data, out_ready, out_latency[LW +: LW], out_latency[0 +: LW],
             in_ready, out_valid, out_data, in_latency,
             dispatch_count[0 +: CW], dispatch_count[CW +: CW]);
  endtask

  initial begin
    //          iv  d       rdy    l1      l0      ir  ov     od      lat     c0 c1
    vt[0]  = '{1, 10'h2A1, 2'b11, 10'd5,  10'd3,  1, 2'b00, 10'h000, 10'd3,  0, 0};
    vt[1]  = '{0, 10'h000, 2'b11, 10'd5,  10'd3,  1, 2'b01, 10'h2A1, 10'd3,  0, 0};
    vt[2]  = '{1, 10'h011, 2'b11, 10'd4,  10'd4,  1, 2'b00, 10'h2A1, 10'd4,  1, 0};
    vt[3]  = '{1, 10'h022, 2'b11, 10'd4,  10'd4,  1, 2'b10, 10'h011, 10'd4,  1, 0};
    vt[4]  = '{1, 10'h033, 2'b11, 10'd4,  10'd4,  1, 2'b01, 10'h022, 10'd4,  1, 1};
    vt[5]  = '{1, 10'h044, 2'b11, 10'd4,  10'd4,  1, 2'b10, 10'h033, 10'd4,  2, 1};
    vt[6]  = '{0, 10'h000, 2'b11, 10'd4,  10'd4,  1, 2'b01, 10'h044, 10'd4,  2, 2};
    vt[7]  = '{1, 10'h055, 2'b11, 10'd6,  10'd2,  1, 2'b00, 10'h044, 10'd2,  3, 2};
    vt[8]  = '{1, 10'h066, 2'b10, 10'd6,  10'd2,  0, 2'b01, 10'h055, 10'd3,  3, 2};
    vt[9]  = '{1, 10'h066, 2'b10, 10'd6,  10'd2,  0, 2'b01, 10'h055, 10'd3,  3, 2};
    vt[10] = '{1, 10'h066, 2'b10, 10'd6,  10'd2,  0, 2'b01, 10'h055, 10'd3,  3, 2};
    vt[11] = '{1, 10'h066, 2'b01, 10'd6,  10'd2,  1, 2'b01, 10'h055, 10'd2,  3, 2};
    vt[12] = '{0, 10'h000, 2'b11, 10'd6,  10'd2,  1, 2'b01, 10'h066, 10'd2,  4, 2};
    vt[13] = '{1, 10'h077, 2'b00, 10'h3FF, 10'h3FF, 1, 2'b00, 10'h066, 10'h3FF, 5, 2};
    vt[14] = '{0, 10'h000, 2'b00, 10'h3FF, 10'h3FF, 0, 2'b10, 10'h077, 10'h3FF, 5, 2};
    vt[15] = '{0, 10'h000, 2'b00, 10'd9,  10'd1,  0, 2'b10, 10'h077, 10'd2,  5, 2};
    vt[16] = '{0, 10'h000, 2'b01, 10'd9,  10'd1,  0, 2'b10, 10'h077, 10'd2,  5, 2};
    vt[17] = '{0, 10'h000, 2'b10, 10'd9,  10'd1,  1, 2'b10, 10'h077, 10'd1,  5, 2};
    vt[18] = '{0, 10'h000, 2'b11, 10'h3FE, 10'h3FE, 1, 2'b00, 10'h077, 10'h3FE, 5, 3};

    // Reset state
    out_latency = {10'd7, 10'd9};
    #2;
    check_all("reset", 1'b1, 2'b00, 10'h000, 10'd7, 0, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      in_valid    = vt[i].iv;
      in_data     = vt[i].d;
      out_ready   = vt[i].rdy;
      out_latency = {vt[i].l1, vt[i].l0};
      #1;
      check_all($sformatf("v%0d", i), vt[i].e_ir, vt[i].e_ov, vt[i].e_od,
                vt[i].e_lat, vt[i].e_c0, vt[i].e_c1);
      tick();
    end

    // Stalled at 0x3FE: estimate reaches 0x3FF exactly.
    in_valid    = 1'b1;
    in_data     = 10'h155;
    out_ready   = 2'b00;
    out_latency = {10'h3FE, 10'h3FE};
    tick();
    in_valid = 1'b0;
    #1;
    check_all("sat3fe", 1'b0, 2'b01, 10'h155, 10'h3FF, 5, 3);

    // Asynchronous reset while FULL with nonzero counters, no clock edge.
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b1, 2'b00, 10'h000, 10'h3FE, 0, 0);
    #1;
    rst = 1'b0;
    tick();

    // Counter wrap: 2^CW transfers to ch1.
    out_latency = {10'd0, 10'd5};
    out_ready   = 2'b11;
    in_valid    = 1'b1;
    in_data     = 10'h3C2;
    for (int i = 0; i < 256; i++) tick();
    #1;
    check_all("wrap255", 1'b1, 2'b10, 10'h3C2, 10'd0, 0, 8'd255);
    in_valid = 1'b0;
    tick();
    #1;
    check_all("wrap0", 1'b1, 2'b00, 10'h3C2, 10'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
